// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-side request responder: buffered request entry and
// responder FSM state encoding.
package data_mem_responder_pkg;

   typedef struct packed {
      logic        wr;
      logic        iscache;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } data_req_entry_t;

   typedef enum logic [1:0] {
      RSP_IDLE,
      RSP_REQ,
      RSP_WAIT,
      RSP_RESP
   } rsp_state_t;

   function automatic logic [31:0] pack_addr(input logic [19:0] tag,
                                             input logic [7:0]  index,
                                             input logic [3:0]  offset);
      return {tag, index, offset};
   endfunction

endpackage

// File: rtl/data_mem_responder_req_fifo.sv
// In-order request buffer: synchronous FIFO with power-of-two depth, exposing the
// head entry combinationally.
module req_fifo
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter type         T     = data_req_entry_t
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  T     push_data,
   input  logic pop,
   output logic full,
   output logic empty,
   output T     head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   T                 mem_q [DEPTH];
   T                 mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; validity is tracked by the count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/data_mem_responder.sv
// Data-side responder: buffers accepted pre-MEM requests in order, issues them one at
// a time to the backend memory port and returns one data_data_ok pulse per request.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_req,
   input  logic        data_iscache,
   input  logic        data_wr,
   input  logic [3:0]  data_offset,
   input  logic [7:0]  data_index,
   input  logic [19:0] data_tag,
   input  logic [2:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic        mem_cached,
   output logic [31:0] mem_addr,
   output logic [2:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   data_req_entry_t push_entry;
   data_req_entry_t head_entry;
   data_req_entry_t issue_entry;
   logic            fifo_full;
   logic            fifo_empty;
   logic            push;
   logic            pop;
   logic            have_work;

   rsp_state_t      state_q, state_d;
   logic            mem_req_q, mem_req_d;
   data_req_entry_t mem_ent_q, mem_ent_d;
   logic            data_data_ok_q, data_data_ok_d;
   logic [31:0]     data_rdata_q, data_rdata_d;

   req_fifo #(
      .DEPTH (DEPTH),
      .T     (data_req_entry_t)
   ) u_req_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head_entry)
   );

   always_comb begin
      push_entry.wr      = data_wr;
      push_entry.iscache = data_iscache;
      push_entry.addr    = pack_addr(data_tag, data_index, data_offset);
      push_entry.size    = data_size;
      push_entry.wstrb   = data_wstrb;
      push_entry.wdata   = data_wdata;

      data_addr_ok = data_req && !fifo_full;
      push         = data_addr_ok;
      have_work    = !fifo_empty || push;

      // The next head is the entry being pushed when the buffer is currently empty;
      // issuing it from the register keeps push->mem_req a one-cycle registered path.
      issue_entry = fifo_empty ? push_entry : head_entry;
      if (!issue_entry.wr) begin
         issue_entry.wstrb = '0;
      end

      state_d        = state_q;
      mem_req_d      = mem_req_q;
      mem_ent_d      = mem_ent_q;
      data_data_ok_d = 1'b0;
      data_rdata_d   = data_rdata_q;
      pop            = 1'b0;

      case (state_q)
         RSP_IDLE: begin
            if (have_work) begin
               state_d   = RSP_REQ;
               mem_req_d = 1'b1;
               mem_ent_d = issue_entry;
            end
         end
         RSP_REQ: begin
            if (mem_gnt) begin
               state_d   = RSP_WAIT;
               mem_req_d = 1'b0;
            end
         end
         RSP_WAIT: begin
            if (mem_rvalid) begin
               pop            = 1'b1;
               data_rdata_d   = head_entry.wr ? '0 : mem_rdata;
               data_data_ok_d = 1'b1;
               state_d        = RSP_RESP;
            end
         end
         RSP_RESP: begin
            if (have_work) begin
               state_d   = RSP_REQ;
               mem_req_d = 1'b1;
               mem_ent_d = issue_entry;
            end else begin
               state_d = RSP_IDLE;
            end
         end
         default: begin
            state_d   = RSP_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= RSP_IDLE;
         mem_req_q      <= 1'b0;
         mem_ent_q      <= '0;
         data_data_ok_q <= 1'b0;
         data_rdata_q   <= '0;
      end else begin
         state_q        <= state_d;
         mem_req_q      <= mem_req_d;
         mem_ent_q      <= mem_ent_d;
         data_data_ok_q <= data_data_ok_d;
         data_rdata_q   <= data_rdata_d;
      end
   end

   assign data_data_ok = data_data_ok_q;
   assign data_rdata   = data_rdata_q;
   assign mem_req      = mem_req_q;
   assign mem_wr       = mem_ent_q.wr;
   assign mem_cached   = mem_ent_q.iscache;
   assign mem_addr     = mem_ent_q.addr;
   assign mem_size     = mem_ent_q.size;
   assign mem_wstrb    = mem_ent_q.wstrb;
   assign mem_wdata    = mem_ent_q.wdata;

endmodule
